// File: rtl/wb_vram_responder.sv
// Wishbone B3 slave in front of the VRAM block RAM. It handles classic cycles and
// registered-feedback incrementing bursts (linear, wrap-4/8/16) with byte-lane writes.
module wb_vram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [31:2] wbs_addr_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Wrapping bursts only advance the low 2/3/4 bits; linear wraps the whole window.
  function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] addr,
                                                     input logic [1:0] bte);
    logic [ADDR_BITS-1:0] inc;
    logic [ADDR_BITS-1:0] mask;
    inc = addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    case (bte)
      2'b01:   mask = {{(ADDR_BITS-2){1'b0}}, 2'b11};
      2'b10:   mask = {{(ADDR_BITS-3){1'b0}}, 3'b111};
      2'b11:   mask = {{(ADDR_BITS-4){1'b0}}, 4'b1111};
      default: mask = {ADDR_BITS{1'b1}};
    endcase
    return (addr & ~mask) | (inc & mask);
  endfunction

  logic [31:0]          mem_r [DEPTH];
  state_t               state_r, state_s;
  logic                 ack_r, ack_s;
  logic                 err_r, err_s;
  logic [31:0]          data_r;
  logic [ADDR_BITS-1:0] addr_r, addr_s;
  logic                 rd_en_s;
  logic                 wr_en_s;
  logic [ADDR_BITS-1:0] wr_addr_s;
  logic                 hit_s;
  logic [ADDR_BITS-1:0] idx_s;
  logic                 incr_s;
  logic                 last_s;
  logic                 beat_s;

  assign hit_s  = (wbs_addr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign idx_s  = wbs_addr_i[ADDR_BITS+1:2];
  assign incr_s = (wbs_cti_i == 3'b010);
  assign last_s = (wbs_cti_i == 3'b111);
  assign beat_s = ack_r & wbs_stb_i;

  // Next-state, acknowledge and RAM-port control decode
  always_comb begin
    state_s   = state_r;
    ack_s     = 1'b0;
    err_s     = 1'b0;
    addr_s    = addr_r;
    rd_en_s   = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = addr_r;
    if (!wbs_cyc_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!wbs_stb_i) begin
            state_s = IDLE;
          end else if (!hit_s) begin
            err_s   = 1'b1;
            state_s = DONE;
          end else if (wbs_we_i) begin
            wr_en_s   = 1'b1;
            wr_addr_s = idx_s;
            addr_s    = idx_s;
            ack_s     = 1'b1;
            state_s   = incr_s ? WR_BURST : DONE;
          end else begin
            addr_s  = idx_s;
            state_s = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!wbs_stb_i) begin
            state_s = IDLE;
          end else if (incr_s) begin
            rd_en_s = 1'b1;
            ack_s   = 1'b1;
            addr_s  = next_addr(addr_r, wbs_bte_i);
            state_s = RD_BURST;
          end else begin
            rd_en_s = 1'b1;
            ack_s   = 1'b1;
            state_s = DONE;
          end
        end
        RD_BURST: begin
          // A paused beat is re-requested by the master as a fresh first beat.
          if (!beat_s) begin
            state_s = IDLE;
          end else if (last_s) begin
            state_s = DONE;
          end else begin
            ack_s   = 1'b1;
            rd_en_s = 1'b1;
            addr_s  = next_addr(addr_r, wbs_bte_i);
          end
        end
        WR_BURST: begin
          if (!beat_s) begin
            state_s = IDLE;
          end else if (last_s) begin
            wr_en_s = 1'b1;
            state_s = DONE;
          end else begin
            wr_en_s = 1'b1;
            ack_s   = 1'b1;
            addr_s  = next_addr(addr_r, wbs_bte_i);
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Control state, bus handshake outputs and the RAM output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      data_r  <= 32'h0000_0000;
      addr_r  <= {ADDR_BITS{1'b0}};
    end else begin
      state_r <= state_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
      addr_r  <= addr_s;
      if (rd_en_s) begin
        data_r <= mem_r[addr_r];
      end
    end
  end

  // Byte-lane write port; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && wbs_sel_i[i]) begin
        mem_r[wr_addr_s][8*i +: 8] <= wbs_data_i[8*i +: 8];
      end
    end
  end

  assign wbs_data_o = data_r;
  assign wbs_ack_o  = ack_r;
  assign wbs_err_o  = err_r;

endmodule

// File: tb/tb_wb_vram_responder.sv
// Directed bench for wb_vram_responder: classic, byte lanes, bursts, pause, miss and abort.
module tb_wb_vram_responder;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:2] addr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic [29:0] wa;

  int n_total = 0;
  int n_pass  = 0;

  wb_vram_responder #(
    .BASE_ADDR(32'h0000_0000),
    .ADDR_BITS(12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_addr_i(addr),
    .wbs_cti_i (cti),
    .wbs_bte_i (bte),
    .wbs_sel_i (sel),
    .wbs_we_i  (we),
    .wbs_data_i(dat_w),
    .wbs_data_o(dat_r),
    .wbs_ack_o (ack),
    .wbs_err_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    cti   = 3'b000;
    bte   = 2'b00;
    sel   = 4'b0000;
    dat_w = 32'h0000_0000;
  endtask

  task automatic wr_classic(input logic [31:2] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; cti = 3'b000; bte = 2'b00; sel = s; dat_w = d;
    step();
    chk("wr_ack", {31'd0, ack}, 32'd1);
    chk("wr_err", {31'd0, err}, 32'd0);
    step();
    chk("wr_ack_drop", {31'd0, ack}, 32'd0);
    bus_idle();
  endtask

  task automatic rd_classic(input logic [31:2] a, input logic [31:0] exp, input string tag);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; cti = 3'b000; bte = 2'b00; sel = 4'b1111;
    step();
    chk("rd_latency", {31'd0, ack}, 32'd0);
    step();
    chk("rd_ack", {31'd0, ack}, 32'd1);
    chk(tag, dat_r, exp);
    step();
    chk("rd_ack_drop", {31'd0, ack}, 32'd0);
    bus_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = 30'd0;
    bus_idle();
    repeat (3) step();
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_data", dat_r, 32'h0000_0000);
    rst_n = 1'b1;
    step();

    // Classic write then read
    wr_classic(30'd5, 32'hDEAD_BEEF, 4'b1111);
    rd_classic(30'd5, 32'hDEAD_BEEF, "classic_rd");

    // Byte lanes; the output register must hold through writes
    wr_classic(30'd7, 32'h1122_3344, 4'b1111);
    wr_classic(30'd7, 32'hAAAA_AAAA, 4'b0101);
    chk("data_hold_wr", dat_r, 32'hDEAD_BEEF);
    rd_classic(30'd7, 32'h11AA_33AA, "byte_lane");

    for (int i = 0; i < 8; i++) begin
      wr_classic(30'(i), 32'hC0DE_0000 + 32'(i), 4'b1111);
    end

    // Wrap-8 read burst from word 6
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'd6; cti = 3'b010; bte = 2'b10; sel = 4'b1111;
    step();
    chk("wrap8_latency", {31'd0, ack}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      wa = 30'((6 + k) % 8);
      step();
      addr = wa;
      cti  = (k == 7) ? 3'b111 : 3'b010;
      chk("wrap8_ack", {31'd0, ack}, 32'd1);
      chk("wrap8_data", dat_r, 32'hC0DE_0000 + {2'b00, wa});
    end
    step();
    chk("wrap8_end", {31'd0, ack}, 32'd0);
    bus_idle();
    step();

    // Linear write burst across the top of the window
    cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = 2'b00; sel = 4'b1111;
    addr = 30'd4094; dat_w = 32'h5A5A_0000; cti = 3'b010;
    step();
    chk("wrlin_ack0", {31'd0, ack}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("wrlin_ack", {31'd0, ack}, 32'd1);
      addr  = 30'((4094 + k) % 4096);
      dat_w = 32'h5A5A_0000 + 32'(k);
      cti   = (k == 3) ? 3'b111 : 3'b010;
    end
    step();
    chk("wrlin_end", {31'd0, ack}, 32'd0);
    bus_idle();
    step();
    rd_classic(30'd4094, 32'h5A5A_0000, "wrlin_4094");
    rd_classic(30'd4095, 32'h5A5A_0001, "wrlin_4095");
    rd_classic(30'd0,    32'h5A5A_0002, "wrlin_0");
    rd_classic(30'd1,    32'h5A5A_0003, "wrlin_1");
    rd_classic(30'd2,    32'hC0DE_0002, "wrlin_no_spill");

    // Linear read burst with a two-cycle strobe pause after the first beat
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'd4094; cti = 3'b010; bte = 2'b00;
    step();
    chk("pause_lat", {31'd0, ack}, 32'd0);
    step();
    chk("pause_b0", dat_r, 32'h5A5A_0000);
    step();
    chk("pause_pre_ack", {31'd0, ack}, 32'd1);
    chk("pause_pre_data", dat_r, 32'h5A5A_0001);
    stb = 1'b0;
    step();
    chk("pause_ack_low", {31'd0, ack}, 32'd0);
    step();
    chk("pause_ack_low2", {31'd0, ack}, 32'd0);
    chk("pause_data_hold", dat_r, 32'h5A5A_0001);
    stb = 1'b1; addr = 30'd4095;
    step();
    chk("resume_lat", {31'd0, ack}, 32'd0);
    step();
    chk("resume_b1_ack", {31'd0, ack}, 32'd1);
    chk("resume_b1", dat_r, 32'h5A5A_0001);
    step();
    chk("resume_b2", dat_r, 32'h5A5A_0002);
    addr = 30'd0;
    step();
    chk("resume_b3_ack", {31'd0, ack}, 32'd1);
    chk("resume_b3", dat_r, 32'h5A5A_0003);
    addr = 30'd1; cti = 3'b111;
    step();
    chk("resume_end", {31'd0, ack}, 32'd0);
    bus_idle();
    step();

    // Out-of-window read and write
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'h1000; cti = 3'b000;
    step();
    chk("miss_rd_err", {31'd0, err}, 32'd1);
    chk("miss_rd_ack", {31'd0, ack}, 32'd0);
    step();
    chk("miss_rd_err_drop", {31'd0, err}, 32'd0);
    chk("miss_rd_ack2", {31'd0, ack}, 32'd0);
    bus_idle();
    step();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'h1005; sel = 4'b1111; dat_w = 32'hFFFF_FFFF;
    step();
    chk("miss_wr_err", {31'd0, err}, 32'd1);
    chk("miss_wr_ack", {31'd0, ack}, 32'd0);
    step();
    chk("miss_wr_err_drop", {31'd0, err}, 32'd0);
    bus_idle();
    step();
    rd_classic(30'd5, 32'hC0DE_0005, "miss_ram_intact");

    // Asynchronous reset in the middle of a wrap-4 read burst
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'd2; cti = 3'b010; bte = 2'b01;
    step();
    step();
    chk("rstab_ack", {31'd0, ack}, 32'd1);
    chk("rstab_data", dat_r, 32'hC0DE_0002);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstab_async_ack", {31'd0, ack}, 32'd0);
    chk("rstab_async_err", {31'd0, err}, 32'd0);
    chk("rstab_async_data", dat_r, 32'h0000_0000);
    step();
    chk("rstab_hold_ack", {31'd0, ack}, 32'd0);
    bus_idle();
    #2;
    rst_n = 1'b1;
    step();
    rd_classic(30'd2, 32'hC0DE_0002, "post_rst_rd");

    // Cycle dropped in the middle of a linear read burst
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'd3; cti = 3'b010; bte = 2'b00;
    step();
    step();
    chk("cycab_b0", dat_r, 32'hC0DE_0003);
    step();
    chk("cycab_b1_ack", {31'd0, ack}, 32'd1);
    chk("cycab_b1", dat_r, 32'hC0DE_0004);
    cyc = 1'b0; stb = 1'b0;
    step();
    chk("cycab_ack", {31'd0, ack}, 32'd0);
    chk("cycab_err", {31'd0, err}, 32'd0);
    step();
    chk("cycab_ack2", {31'd0, ack}, 32'd0);
    bus_idle();
    rd_classic(30'd6, 32'hC0DE_0006, "post_abort_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_vram_responder.md
# wb_vram_responder

Wishbone B3 slave fronting an on-chip VRAM block RAM. It is the responder at the far end of the display controllers' VRAM master port. It serves classic single reads and writes, and registered-feedback incrementing bursts (linear and wrap-4/8/16) at one beat per cycle after the first. CPU-side masters write VRAM through the same port via the system arbiter.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte base of the VRAM window; must be aligned to the window size.
- ADDR_BITS, 12: word-address width; depth is 2^ADDR_BITS 32-bit words.

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_addr_i  in  [31:2]  word address.
- wbs_cti_i  in  [2:0]  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; any other code is treated as 000.
- wbs_bte_i  in  [1:0]  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- wbs_sel_i  in  [3:0]  byte enables for writes.
- wbs_we_i  in  1  write enable.
- wbs_data_i  in  32  write data.
- wbs_data_o  out  32  read data; the RAM output register.
- wbs_ack_o  out  1  beat acknowledge; registered.
- wbs_err_o  out  1  error acknowledge for an out-of-window address; registered.

## Operation
- Hit: wbs_addr_i[31:ADDR_BITS+2] equals BASE_ADDR[31:ADDR_BITS+2]. RAM index is wbs_addr_i[ADDR_BITS+1:2].
- A request is cyc & stb while the FSM is in IDLE. Beat accepted: ack_o & stb_i at a clock edge.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_BURST, DONE.
- IDLE, miss: err_o=1 for one cycle, then DONE. No RAM access.
- IDLE, hit, write: RAM written with sel_i byte lanes, ack_o=1.
  - cti=010: go to WR_BURST.
  - Otherwise: go to DONE.
- IDLE, hit, read: RAM read issued, go to RD_WAIT.
- RD_WAIT: RAM data is available and ack_o=1.
  - cti=010: go to RD_BURST and issue the predicted next address (next_addr).
  - Otherwise: go to DONE.
- RD_BURST / WR_BURST, on each accepted beat:
  - cti_i=111: this is the final beat; ack_o=0 next cycle, go to DONE.
  - Otherwise: keep ack_o=1, advance the address with next_addr, read the predicted word or write the presented word.
- Burst pause: stb_i=0 with cyc_i=1 in a burst state. ack_o=0, the current address is held, and the FSM returns to IDLE. When stb returns, the access restarts as a first beat at the held address, so a read pays one extra cycle.
- DONE: ack_o=0 and err_o=0. Return to IDLE next cycle. This stops a classic master from seeing a double acknowledge.
- cyc_i=0 in any state: next state IDLE, ack_o=0, err_o=0. An unaccepted predicted read is discarded.
- next_addr is the word index plus 1.
  - Linear: wraps modulo 2^ADDR_BITS, staying inside the window.
  - Wrap-4/8/16: only the low 2/3/4 bits increment modulo 4/8/16; upper bits are held.
- A write beat never modifies the lanes whose sel_i bit is 0.
- Reads ignore sel_i and always return the full word.

## Timing
- Reset (rst_n=0, asynchronous, valid at any point mid-cycle): FSM=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_data_o=0. RAM contents are not cleared.
- Classic read: stb sampled at edge E0, ack_o high after E1, ack_o low after E2 (DONE).
- Classic write or error: stb sampled at E0, ack_o/err_o high after E0, low after E1.
- Read burst of N beats: first ack after E1. Beat k is acknowledged in the cycle after edge E(k). The last ack falls at the edge that samples cti=111.
- Write burst of N beats: acknowledged after E0 through E(N-1).
- ack_o and err_o are never both 1.
- wbs_data_o changes only on read issue. It is otherwise held at the last read value, including during writes.
- Read-after-write to the same address in consecutive cycles returns the new data.

## Test plan
- Classic: write 32'hDEAD_BEEF, sel=4'b1111, to word 5, then read word 5. Required: read returns DEAD_BEEF, ack is high for exactly one cycle each time, and the read ack arrives two edges after the strobe.
- Byte lanes: write 32'h1122_3344 to word 7, then write 32'hAAAA_AAAA with sel=4'b0101. Required: readback is 32'h11AA_33AA.
- Wrap-8 read burst starting at word 6, 8 beats. Required: words 6, 7, 0, 1, 2, 3, 4, 5 in that order, and ack held high for 8 consecutive cycles after the first-beat latency.
- Linear write burst of 4 beats starting at word 2^ADDR_BITS-2. Required: the writes land at words 4094, 4095, 0, 1. Then drop stb for 2 cycles mid read-burst. Required: ack goes low, and the burst resumes at the held address with no beat skipped or duplicated.
- Miss: read at BASE_ADDR + 4·2^ADDR_BITS. Required: err_o is a single-cycle pulse, ack_o stays 0, and RAM is unchanged.
- Abort: assert rst_n=0 during a read burst, and separately drop cyc during a read burst. Required: ack/err go to 0 immediately and stay 0. The next classic read returns correct data.
